// File: rtl/alarm_game_multi.sv
// Multi-channel alarm with an LFSR-driven switch-matching dismissal game.
// Optional snooze support is compiled in with `define SNOOZE_EN.
module alarm_game_multi #(
  parameter int unsigned N_LED        = 10,
  parameter int unsigned N_ALARM      = 2,
  parameter int unsigned TIME_W       = 16,
  parameter int unsigned ROUNDS       = 3,
  parameter int unsigned ROUND_TICKS  = 1000,
  parameter int unsigned SNOOZE_TICKS = 5000,
  localparam int unsigned AW = (N_ALARM > 1) ? $clog2(N_ALARM) : 1
) (
  input  logic                      s2clk,
  input  logic                      reset,
  input  logic                      enable,
  input  logic [TIME_W-1:0]         current,
  input  logic [N_ALARM*TIME_W-1:0] alarm_times,
  input  logic [N_ALARM-1:0]        alarm_en,
  input  logic                      push_m,
  input  logic                      push_s,
  input  logic [N_LED-1:0]          SPDTs,
  output logic [2:0]                alarm_state,
  output logic [AW-1:0]             active_alarm,
  output logic [N_LED-1:0]          target_led,
  output logic [3:0]                round_count,
  output logic                      ringing,
  output logic                      done_pulse
);

  localparam int unsigned IdxW   = $clog2(N_LED);
  localparam int unsigned TimerW = $clog2(ROUND_TICKS);

  localparam logic [2:0] StOff    = 3'b000;
  localparam logic [2:0] StArmed  = 3'b001;
  localparam logic [2:0] StRing   = 3'b010;
  localparam logic [2:0] StGame   = 3'b100;
  localparam logic [2:0] StDone   = 3'b011;
  localparam logic [2:0] StSnooze = 3'b110;

  logic [2:0]        state_q, state_d;
  logic [15:0]       lfsr_q, lfsr_d;
  logic [IdxW-1:0]   last_idx_q, last_idx_d;
  logic [N_LED-1:0]  target_q, target_d;
  logic [3:0]        round_q, round_d;
  logic [TimerW-1:0] timer_q, timer_d;
  logic              need_clear_q, need_clear_d;
  logic [AW-1:0]     active_q, active_d;
  logic [TIME_W-1:0] last_fired_q, last_fired_d;
  logic              fired_valid_q, fired_valid_d;
  logic              push_m_q;

`ifdef SNOOZE_EN
  localparam int unsigned SnW = (SNOOZE_TICKS > 1) ? $clog2(SNOOZE_TICKS) : 1;
  logic [SnW-1:0] snooze_q, snooze_d;
`else
  logic unused_push_s;
  assign unused_push_s = push_s;
`endif

  logic [N_ALARM-1:0] match;
  logic [N_ALARM-1:0] scan;
  logic               hit;
  logic [AW-1:0]      hit_idx;
  logic [IdxW-1:0]    idx_raw, new_idx;
  logic [N_LED-1:0]   new_target;
  logic               push_m_rise;

  for (genvar g = 0; g < N_ALARM; g++) begin : g_match
    assign match[g] = alarm_en[g] && (current == alarm_times[g*TIME_W +: TIME_W]);
  end

  // Lowest matching channel wins; suppressed while time still equals the last dismissal.
  always_comb begin
    hit     = 1'b0;
    hit_idx = '0;
    scan    = match;
    for (int i = 0; i < int'(N_ALARM); i++) begin
      if (!hit && scan[0]) begin
        hit     = 1'b1;
        hit_idx = AW'(i);
      end
      scan = scan >> 1;
    end
    if (fired_valid_q && (current == last_fired_q)) hit = 1'b0;
  end

  always_comb begin
    idx_raw    = IdxW'(lfsr_q % 16'(N_LED));
    new_idx    = idx_raw;
    if (idx_raw == last_idx_q) begin
      new_idx = (idx_raw == IdxW'(N_LED - 1)) ? '0 : idx_raw + IdxW'(1);
    end
    new_target = N_LED'(1) << new_idx;
  end

  assign lfsr_d      = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
  assign push_m_rise = push_m && !push_m_q;

  always_comb begin
    state_d       = state_q;
    last_idx_d    = last_idx_q;
    target_d      = target_q;
    round_d       = round_q;
    timer_d       = timer_q;
    need_clear_d  = need_clear_q;
    active_d      = active_q;
    last_fired_d  = last_fired_q;
    fired_valid_d = fired_valid_q;
`ifdef SNOOZE_EN
    snooze_d      = snooze_q;
`endif
    // Suppression lapses once time moves on, so the same alarm can fire again later.
    if (fired_valid_q && (current != last_fired_q)) fired_valid_d = 1'b0;

    case (state_q)
      StOff: state_d = StArmed;
      StArmed: begin
        if (hit) begin
          state_d  = StRing;
          active_d = hit_idx;
        end
      end
      StRing: begin
        if (push_m_rise) begin
          state_d      = StGame;
          round_d      = '0;
          timer_d      = '0;
          target_d     = new_target;
          last_idx_d   = new_idx;
          need_clear_d = 1'b1;
        end
`ifdef SNOOZE_EN
        else if (push_s) begin
          state_d  = StSnooze;
          snooze_d = '0;
        end
`endif
      end
      StGame: begin
        // Any switch action wins over a timeout in the same cycle.
        if (!need_clear_q && (SPDTs != '0)) begin
          timer_d = '0;
          if ((SPDTs == target_q) && (round_q == 4'(ROUNDS - 1))) begin
            state_d  = StDone;
            round_d  = '0;
            target_d = '0;
          end else begin
            round_d      = (SPDTs == target_q) ? round_q + 4'd1 : 4'd0;
            target_d     = new_target;
            last_idx_d   = new_idx;
            need_clear_d = 1'b1;
          end
        end else begin
          if (SPDTs == '0) need_clear_d = 1'b0;
          if (timer_q == TimerW'(ROUND_TICKS - 1)) begin
            state_d      = StRing;
            round_d      = '0;
            target_d     = '0;
            timer_d      = '0;
            need_clear_d = 1'b0;
          end else begin
            timer_d = timer_q + TimerW'(1);
          end
        end
      end
      StDone: begin
        state_d       = StArmed;
        last_fired_d  = current;
        fired_valid_d = 1'b1;
      end
`ifdef SNOOZE_EN
      StSnooze: begin
        if (snooze_q == SnW'(SNOOZE_TICKS - 1)) state_d = StRing;
        else snooze_d = snooze_q + SnW'(1);
      end
`endif
      default: state_d = StOff;
    endcase

    if (!enable) begin
      state_d      = StOff;
      timer_d      = '0;
      round_d      = '0;
      target_d     = '0;
      need_clear_d = 1'b0;
    end
  end

  always_ff @(posedge s2clk or negedge reset) begin
    if (!reset) begin
      state_q       <= StOff;
      lfsr_q        <= 16'hACE1;
      last_idx_q    <= '0;
      target_q      <= '0;
      round_q       <= '0;
      timer_q       <= '0;
      need_clear_q  <= 1'b0;
      active_q      <= '0;
      last_fired_q  <= '1;
      fired_valid_q <= 1'b0;
      push_m_q      <= 1'b0;
`ifdef SNOOZE_EN
      snooze_q      <= '0;
`endif
    end else begin
      state_q       <= state_d;
      lfsr_q        <= lfsr_d;
      last_idx_q    <= last_idx_d;
      target_q      <= target_d;
      round_q       <= round_d;
      timer_q       <= timer_d;
      need_clear_q  <= need_clear_d;
      active_q      <= active_d;
      last_fired_q  <= last_fired_d;
      fired_valid_q <= fired_valid_d;
      push_m_q      <= push_m;
`ifdef SNOOZE_EN
      snooze_q      <= snooze_d;
`endif
    end
  end

  assign alarm_state  = state_q;
  assign active_alarm = active_q;
  assign target_led   = target_q;
  assign round_count  = round_q;
  assign ringing      = (state_q == StRing);
  assign done_pulse   = (state_q == StDone);

endmodule

// File: tb/tb_alarm_game_multi.sv
// Directed bench for alarm_game_multi; expected targets come from an independent LFSR model.
module tb_alarm_game_multi;

  localparam int unsigned NLed   = 10;
  localparam int unsigned RTicks = 1000;

  logic        s2clk = 1'b0;
  logic        reset;
  logic        enable;
  logic [15:0] current;
  logic [31:0] alarm_times;
  logic [1:0]  alarm_en;
  logic        push_m;
  logic        push_s;
  logic [9:0]  SPDTs;
  logic [2:0]  alarm_state;
  logic [0:0]  active_alarm;
  logic [9:0]  target_led;
  logic [3:0]  round_count;
  logic        ringing;
  logic        done_pulse;

  int          n_cmp = 0;
  int          n_err = 0;
  int          done_cnt = 0;
  logic [15:0] m_lfsr;
  logic [3:0]  m_last_idx = 4'd0;
  logic [9:0]  cur_tgt;
  logic [9:0]  prev_tgt;
  logic [31:0] exp_q[$];

  alarm_game_multi #(
    .N_LED       (10),
    .N_ALARM     (2),
    .TIME_W      (16),
    .ROUNDS      (3),
    .ROUND_TICKS (1000),
    .SNOOZE_TICKS(20)
  ) dut (
    .s2clk       (s2clk),
    .reset       (reset),
    .enable      (enable),
    .current     (current),
    .alarm_times (alarm_times),
    .alarm_en    (alarm_en),
    .push_m      (push_m),
    .push_s      (push_s),
    .SPDTs       (SPDTs),
    .alarm_state (alarm_state),
    .active_alarm(active_alarm),
    .target_led  (target_led),
    .round_count (round_count),
    .ringing     (ringing),
    .done_pulse  (done_pulse)
  );

  always #5 s2clk = ~s2clk;

  always @(posedge s2clk or negedge reset) begin
    if (!reset) m_lfsr <= 16'hACE1;
    else        m_lfsr <= {m_lfsr[14:0], m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10]};
  end

  always @(negedge s2clk) if (done_pulse === 1'b1) done_cnt++;

  function automatic logic [9:0] pick(input logic [15:0] l);
    logic [3:0] idx;
    idx = 4'(l % 16'(NLed));
    if (idx == m_last_idx) idx = (idx == 4'(NLed - 1)) ? 4'd0 : idx + 4'd1;
    m_last_idx = idx;
    return 10'd1 << idx;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge s2clk);
  endtask

  // Queue the target the DUT should load from the LFSR on the coming edge.
  task automatic expect_new_target();
    cur_tgt = pick(m_lfsr);
    exp_q.push_back(32'(cur_tgt));
  endtask

  task automatic check_target(input string tag);
    logic [31:0] e;
    if (exp_q.size() == 0) begin
      n_cmp++;
      n_err++;
      $error("FAIL %s: observed empty scoreboard expected entry", tag);
    end else begin
      e = exp_q.pop_front();
      check(tag, 32'(target_led), e);
    end
  endtask

  task automatic enter_game(input string tag);
    expect_new_target();
    push_m = 1'b1;
    step();
    push_m = 1'b0;
    check({tag, "_state"}, 32'(alarm_state), 32'h4);
    check({tag, "_round"}, 32'(round_count), 32'd0);
    check_target({tag, "_tgt"});
  endtask

  task automatic good_hit(input int exp_round);
    SPDTs = cur_tgt;
    expect_new_target();
    step();
    check("hit_round", 32'(round_count), 32'(exp_round));
    check_target("hit_tgt");
    SPDTs = '0;
    step();
  endtask

  initial begin
    reset = 1'b0; enable = 1'b0; current = 16'h0; alarm_times = '0; alarm_en = '0;
    push_m = 1'b0; push_s = 1'b0; SPDTs = '0;
    step();
    check("rst_state", 32'(alarm_state), 32'h0);
    check("rst_ring", 32'(ringing), 32'h0);
    check("rst_tgt", 32'(target_led), 32'h0);
    check("rst_round", 32'(round_count), 32'h0);
    check("rst_done", 32'(done_pulse), 32'h0);
    check("rst_active", 32'(active_alarm), 32'h0);
    reset = 1'b1;
    step();
    check("off_held", 32'(alarm_state), 32'h0);

    enable = 1'b1; alarm_en = 2'b01; alarm_times = {16'h0900, 16'h0730}; current = 16'h0729;
    step();
    check("armed", 32'(alarm_state), 32'h1);
    step();
    check("armed_nomatch", 32'(alarm_state), 32'h1);
    current = 16'h0730;
    step();
    check("ring_state", 32'(alarm_state), 32'h2);
    check("ring_active", 32'(active_alarm), 32'h0);
    check("ring_flag", 32'(ringing), 32'h1);

    enter_game("game1");
    step();
    good_hit(1);
    prev_tgt = cur_tgt;
    SPDTs = ~cur_tgt;
    expect_new_target();
    step();
    check("wrong_round", 32'(round_count), 32'd0);
    check_target("wrong_tgt");
    check("wrong_tgt_changed", 32'(target_led != prev_tgt), 32'd1);
    SPDTs = '0;
    step();
    good_hit(1);
    good_hit(2);
    SPDTs = cur_tgt;
    step();
    check("done_state", 32'(alarm_state), 32'h3);
    check("done_pulse", 32'(done_pulse), 32'h1);
    check("done_round", 32'(round_count), 32'h0);
    check("done_tgt", 32'(target_led), 32'h0);
    SPDTs = '0;
    step();
    check("rearm_state", 32'(alarm_state), 32'h1);
    check("rearm_pulse", 32'(done_pulse), 32'h0);
    for (int i = 0; i < 5; i++) begin
      step();
      check("no_reretrigger", 32'(alarm_state), 32'h1);
    end
    check("done_once", 32'(done_cnt), 32'd1);

    alarm_times = {16'h0900, 16'h0745}; current = 16'h0745;
    step();
    check("ring2_state", 32'(alarm_state), 32'h2);
    push_s = 1'b1;
    step();
`ifdef SNOOZE_EN
    push_s = 1'b0;
    check("snooze_enter", 32'(alarm_state), 32'h6);
    repeat (19) step();
    check("snooze_hold", 32'(alarm_state), 32'h6);
    step();
    check("snooze_exit", 32'(alarm_state), 32'h2);
`else
    push_s = 1'b0;
    check("snooze_ignored", 32'(alarm_state), 32'h2);
`endif

    enter_game("game2");
    repeat (RTicks - 1) step();
    check("timeout_pre", 32'(alarm_state), 32'h4);
    step();
    check("timeout_state", 32'(alarm_state), 32'h2);
    check("timeout_tgt", 32'(target_led), 32'h0);
    check("timeout_round", 32'(round_count), 32'h0);

    enable = 1'b0;
    step();
    check("disable_off", 32'(alarm_state), 32'h0);
    enable = 1'b1; alarm_en = 2'b10; alarm_times = {16'h0810, 16'h0800}; current = 16'h0810;
    step();
    check("ch1_armed", 32'(alarm_state), 32'h1);
    step();
    check("ch1_ring", 32'(alarm_state), 32'h2);
    check("ch1_active", 32'(active_alarm), 32'h1);
    enable = 1'b0;
    step();
    enable = 1'b1; alarm_en = 2'b11; alarm_times = {16'h0800, 16'h0800}; current = 16'h0800;
    step();
    check("both_armed", 32'(alarm_state), 32'h1);
    step();
    check("both_ring", 32'(alarm_state), 32'h2);
    check("both_active", 32'(active_alarm), 32'h0);

    enter_game("game3");
    #2 reset = 1'b0;
    #1;
    check("midrst_state", 32'(alarm_state), 32'h0);
    check("midrst_ring", 32'(ringing), 32'h0);
    check("midrst_tgt", 32'(target_led), 32'h0);
    check("midrst_round", 32'(round_count), 32'h0);
    check("midrst_done", 32'(done_pulse), 32'h0);
    check("midrst_active", 32'(active_alarm), 32'h0);
    m_last_idx = 4'd0;
    repeat (3) step();
    reset = 1'b1;
    step();
    check("post_rst_armed", 32'(alarm_state), 32'h1);
    check("no_extra_done", 32'(done_cnt), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/alarm_game_multi.md
Name: alarm_game_multi

Overview:
- Parametrised successor of the Service_4 alarm/minigame block.
- Watches N_ALARM alarm times against the current time and rings on a match.
- Dismissal requires ROUNDS consecutive correct switch hits against an LFSR-chosen one-hot LED target, with a per-round timeout and re-trigger suppression.
- Sits between the clock/time-keeping service and the LED/switch board I/O.

Parameters:
- N_LED, 10, number of target LEDs / switches (2..16).
- N_ALARM, 2, number of independent alarm channels (1..8).
- TIME_W, 16, width of time words.
- ROUNDS, 3, consecutive correct hits needed to dismiss (1..15).
- ROUND_TICKS, 1000, clocks allowed per round before timeout (>=2).
- SNOOZE_TICKS, 5000, snooze length in clocks (used only with SNOOZE_EN).

Ports:
- s2clk  in  1  system clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-low reset (0 = reset).
- enable  in  1  master alarm switch (SPDT4 equivalent).
- current  in  TIME_W  current time.
- alarm_times  in  N_ALARM*TIME_W  packed alarm times; channel i = bits [i*TIME_W +: TIME_W].
- alarm_en  in  N_ALARM  per-channel enable.
- push_m  in  1  dismiss button, synchronous level.
- push_s  in  1  snooze button; ignored without SNOOZE_EN.
- SPDTs  in  N_LED  player switches.
- alarm_state  out  3  000 OFF, 001 ARMED, 010 RING, 100 GAME, 011 DONE, 110 SNOOZE.
- active_alarm  out  clog2(N_ALARM) (min 1)  index of the channel that fired.
- target_led  out  N_LED  one-hot target; 0 outside GAME.
- round_count  out  4  correct hits so far in this game.
- ringing  out  1  high in RING.
- done_pulse  out  1  one-cycle pulse on dismissal.

Behaviour:
- Reset (reset=0, async):
  - state OFF; all outputs 0.
  - LFSR = 16'hACE1; last_idx = 0; last_fired = all ones; fired_valid = 0.
  - Reset mid-game abandons the game with no done_pulse.
- enable=0 in any state: next state OFF and the round timer clears. OFF with enable=1 goes to ARMED next cycle.
- ARMED:
  - A channel hits when alarm_en[i] && current==alarm_times[i] && !(fired_valid && current==last_fired).
  - The lowest hitting index wins and is latched into active_alarm.
  - Next state RING.
- RING:
  - ringing=1.
  - Rising edge of push_m (registered previous value) goes to GAME.
  - On GAME entry: round_count=0, timer=0, new target loaded, need_clear=1.
- LFSR:
  - 16-bit Fibonacci, taps 16,14,13,11; free-running every cycle except in reset; never zero.
  - New target index = lfsr mod N_LED; if equal to last_idx, use (idx+1) mod N_LED.
  - target_led = 1<<idx; last_idx updated.
  - The target is held stable for the whole round.
- GAME, evaluated each cycle:
  - need_clear=1: wait for SPDTs==0, then clear need_clear. Comparisons are suppressed meanwhile; the timer still runs.
  - SPDTs==0: no action.
  - SPDTs==target_led: round_count+1, new target, timer=0, need_clear=1. If round_count+1==ROUNDS, go to DONE instead.
  - SPDTs nonzero and != target: round_count=0, new target, timer=0, need_clear=1.
  - Timer reaches ROUND_TICKS-1: back to RING; round_count=0; target_led=0.
  - A match and a timeout in the same cycle: the match wins.
- DONE (1 cycle):
  - done_pulse=1; last_fired=current; fired_valid=1; round_count and target cleared.
  - Next state ARMED.
- Re-trigger suppression holds until current != last_fired, so the alarm cannot re-ring within the same time value.
- Two channels with equal times fire once.

Optional Feature:
SNOOZE_EN
- Defined: in RING, push_s=1 (push_m not rising) goes to SNOOZE; snooze counter counts SNOOZE_TICKS clocks, then RING. enable=0 still forces OFF. Simultaneous push_m rising edge and push_s: GAME wins.
- Undefined: push_s is ignored, SNOOZE never occurs, and encoding 110 is unused.

Test Plan:
- Default params; enable=1, alarm_en=2'b01, alarm_times[0]=16'h0730, current 16'h0729 -> 16'h0730 -> alarm_state 001 -> 010 one cycle after the match, active_alarm=0, ringing=1.
- In RING, pulse push_m; each round: drive SPDTs=target_led then 0; repeat 3 times -> round_count 1, 2, then DONE with done_pulse=1 for exactly one cycle, then ARMED, no re-ring while current stays 16'h0730.
- In GAME after 1 hit, drive SPDTs to a wrong nonzero value -> round_count=0, target_led changes to a different one-hot value.
- In GAME, hold SPDTs=0 for ROUND_TICKS clocks -> state 010, target_led=0, round_count=0.
- Both channels set to 16'h0800 and enabled -> single ring, active_alarm=0; assert reset=0 mid-GAME -> all outputs 0 immediately, no done_pulse.
- With SNOOZE_EN (SNOOZE_TICKS=20): push_s in RING -> state 110 for 20 clocks, then 010; without the macro, push_s has no effect.
